sd_drive_arbiter: RTL and testbench
===================================

SD_DRIVE_ARBITER -- requirements
Module: sd_drive_arbiter

Interface
REQ-001 SHALL have parameter NBDRIV, default 4: number of virtual drives (1..8).
REQ-002 SHALL have parameter LBA_W, default 32: sector address width.
REQ-003 SHALL have parameter TIMEOUT, default 2**24: cycles allowed from request issue to sd_ack.
REQ-004 SHALL have port clk_sys, input, 1: sole clock; reset is synchronous and active-high.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port drv_lba, input, NBDRIV x LBA_W: per-drive sector address.
REQ-007 SHALL have ports drv_rd and drv_wr, input, NBDRIV each: per-drive level requests, held until drv_done or drv_err.
REQ-008 SHALL have port drv_buff_din, input, NBDRIV x 8: per-drive write data toward the HPS.
REQ-009 SHALL have ports drv_ack, drv_done, drv_err and drv_buff_wr, output, NBDRIV each: per-drive transfer window, completion pulse, error pulse and gated buffer strobe.
REQ-010 SHALL have ports sd_lba (NBDRIV x LBA_W), sd_rd and sd_wr (NBDRIV each), output: the hps_io request side.
REQ-011 SHALL have ports sd_ack (NBDRIV) and sd_buff_wr (1), input: the hps_io acknowledge side.
REQ-012 SHALL have port sd_buff_din, output, NBDRIV x 8: data returned to hps_io.
REQ-013 SHALL have port img_mounted, input, NBDRIV: per-drive mount-change strobe.
REQ-014 SHALL have ports grant_valid (1) and grant_id (clog2 NBDRIV), output: current owner.

Function
REQ-015 SHALL implement states IDLE, ISSUE, XFER and DONE.
REQ-016 SHALL, in IDLE, select the pending drive (drv_rd|drv_wr) round-robin, starting at last_grant+1 modulo NBDRIV.
REQ-017 SHALL, on selection in IDLE at cycle N, latch drv_lba, latch the op (read over write if both are set; the write stays pending) and enter ISSUE with sd_rd/sd_wr[g] high at cycle N+1.
REQ-018 SHALL drive sd_lba[g] from the latched LBA, holding it stable from ISSUE through DONE; non-granted sd_lba SHALL be 0.
REQ-019 SHALL assert exactly one of sd_rd/sd_wr, only on index g, and only in ISSUE.
REQ-020 SHALL, in ISSUE, move to XFER on sd_ack[g]=1 and deassert sd_rd/sd_wr in the same transition.
REQ-021 SHALL ignore sd_ack on non-granted indices in all states.
REQ-022 SHALL, in XFER, drive drv_ack[g]=1 and drv_buff_wr[g]=sd_buff_wr combinationally; all other drv_ack and drv_buff_wr SHALL be 0.
REQ-023 SHALL leave XFER for DONE when sd_ack[g] falls.
REQ-024 SHALL, in DONE, pulse drv_done[g] for exactly 1 cycle, set last_grant=g and return to IDLE, with the next grant possible on the following cycle.
REQ-025 SHALL count cycles in ISSUE; on reaching TIMEOUT-1 without ack it SHALL pulse drv_err[g] for 1 cycle, deassert the request and return to IDLE.
REQ-026 SHALL, on img_mounted[g] in ISSUE, abort the same way as a timeout (drv_err pulse).
REQ-027 SHALL, on img_mounted[g] in XFER, complete the transfer normally.
REQ-028 SHALL drive sd_buff_din[i] = drv_buff_din[i] as an unregistered pass-through.
REQ-029 SHALL drive grant_valid high in ISSUE, XFER and DONE; grant_id = g, and 0 when idle.
REQ-030 SHALL make a drive that drops its request before grant simply not selected, with no output change.

Reset
REQ-031 SHALL, on reset, enter IDLE and set last_grant=NBDRIV-1 so drive 0 is checked first.
REQ-032 SHALL clear the timeout counter on reset and drive every output to 0 on the cycle after reset.
REQ-033 SHALL, if reset occurs mid-ISSUE or mid-XFER, drop the request and emit no drv_done or drv_err pulse.

Structure
REQ-034 SHALL place the state enum and the default TIMEOUT constant in the shared package sd_arb_pkg.
REQ-035 SHALL contain one sub-module, rr_pick: a combinational round-robin priority encoder (request vector, last grant -> index, valid).

Verification
REQ-036 SHALL cover: drv_rd[2]=1, lba=0x1234 -> sd_rd[2] on the next cycle, sd_lba[2]=0x1234; ack for 512 strobes -> 512 drv_buff_wr[2] pulses, then 1 drv_done[2].
REQ-037 SHALL cover: drives 0,1,3 requesting together -> grants in order 0,1,3, then 0 again if still pending.
REQ-038 SHALL cover: drv_rd[1] and drv_wr[1] both high -> read served first, then write as a separate grant.
REQ-039 SHALL cover: TIMEOUT=16 with no ack -> drv_err pulse 16 cycles after issue, with no drv_done.
REQ-040 SHALL cover: sd_ack[3] pulsed while drive 0 is granted -> ignored; img_mounted[0] in ISSUE -> drv_err[0].
REQ-041 SHALL cover: reset during XFER -> all outputs 0 the next cycle, and the next grant goes to drive 0.

Source files
------------

// File: rtl/sd_arb_pkg.sv
// rtl/sd_arb_pkg.sv - shared types and constants for the SD drive arbiter
package sd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // Default request-to-ack budget in clk_sys cycles.
    localparam int DEFAULT_TIMEOUT = 2**24;

    // Index width that stays legal for a single-drive build.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting after the last grant
module rr_pick
    import sd_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = id_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last,
    output logic [ID_W-1:0] idx,
    output logic            valid
);

    // Slot numbers run last+1 .. last+N and are folded back into 0..N-1.
    function automatic int wrap(input int v);
        return (v >= N) ? (v - N) : v;
    endfunction

    // Walk from the farthest slot to the nearest so the nearest requester wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int off = N; off >= 1; off--) begin
            if (req[wrap(int'(last) + off)]) begin
                idx   = ID_W'(wrap(int'(last) + off));
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sd_drive_arbiter.sv
// rtl/sd_drive_arbiter.sv - shares one hps_io sector channel among virtual drives
module sd_drive_arbiter
    import sd_arb_pkg::*;
#(
    parameter int NBDRIV  = 4,
    parameter int LBA_W   = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int ID_W    = id_width(NBDRIV)
) (
    input  logic                          clk_sys,
    input  logic                          reset,
    input  logic [NBDRIV-1:0][LBA_W-1:0]  drv_lba,
    input  logic [NBDRIV-1:0]             drv_rd,
    input  logic [NBDRIV-1:0]             drv_wr,
    input  logic [NBDRIV-1:0][7:0]        drv_buff_din,
    output logic [NBDRIV-1:0]             drv_ack,
    output logic [NBDRIV-1:0]             drv_done,
    output logic [NBDRIV-1:0]             drv_err,
    output logic [NBDRIV-1:0]             drv_buff_wr,
    output logic [NBDRIV-1:0][LBA_W-1:0]  sd_lba,
    output logic [NBDRIV-1:0]             sd_rd,
    output logic [NBDRIV-1:0]             sd_wr,
    input  logic [NBDRIV-1:0]             sd_ack,
    input  logic                          sd_buff_wr,
    output logic [NBDRIV-1:0][7:0]        sd_buff_din,
    input  logic [NBDRIV-1:0]             img_mounted,
    output logic                          grant_valid,
    output logic [ID_W-1:0]               grant_id
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic [ID_W-1:0]   grant_q;
    logic [ID_W-1:0]   last_grant_q;
    logic [LBA_W-1:0]  lba_q;
    logic              op_rd_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;

    logic [NBDRIV-1:0] err_mask;
    logic [NBDRIV-1:0] pending;
    logic [ID_W-1:0]   pick_idx;
    logic              pick_valid;
    logic              take;
    logic              abort;

    // A drive whose error pulse is showing has not yet had a chance to drop
    // its request, so it sits out the pick for that one cycle.
    assign err_mask = err_q ? (NBDRIV'(1) << grant_q) : '0;
    assign pending  = (drv_rd | drv_wr) & ~err_mask;

    // Write data goes straight back to hps_io, unregistered.
    assign sd_buff_din = drv_buff_din;

    rr_pick #(
        .N    (NBDRIV),
        .ID_W (ID_W)
    ) u_rr_pick (
        .req   (pending),
        .last  (last_grant_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Next-state decision: grant, wait for ack, stream, then complete or abort.
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = ISSUE;
                    take    = 1'b1;
                end
            end
            ISSUE: begin
                if (sd_ack[grant_q]) begin
                    state_d = XFER;
                end else if (img_mounted[grant_q] || (cnt_q == CNT_LAST)) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end
            end
            XFER: begin
                if (!sd_ack[grant_q]) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched request and issue-time counter.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_W'(NBDRIV - 1);
            lba_q        <= '0;
            op_rd_q      <= 1'b0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= abort;
            if (take) begin
                grant_q <= pick_idx;
                lba_q   <= drv_lba[pick_idx];
                op_rd_q <= drv_rd[pick_idx];
            end
            if (state_q == DONE) begin
                last_grant_q <= grant_q;
            end
            if ((state_q == ISSUE) && (state_d == ISSUE)) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
        end
    end

    // Steer request, window, strobe and completion onto the granted index only.
    always_comb begin
        drv_ack     = '0;
        drv_done    = '0;
        drv_err     = '0;
        drv_buff_wr = '0;
        sd_lba      = '0;
        sd_rd       = '0;
        sd_wr       = '0;
        grant_valid = 1'b0;
        grant_id    = '0;
        if (state_q != IDLE) begin
            grant_valid     = 1'b1;
            grant_id        = grant_q;
            sd_lba[grant_q] = lba_q;
        end
        case (state_q)
            ISSUE: begin
                sd_rd[grant_q] = op_rd_q;
                sd_wr[grant_q] = !op_rd_q;
            end
            XFER: begin
                drv_ack[grant_q]     = 1'b1;
                drv_buff_wr[grant_q] = sd_buff_wr;
            end
            DONE: begin
                drv_done[grant_q] = 1'b1;
            end
            default: begin
            end
        endcase
        if (err_q) begin
            drv_err[grant_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_sd_drive_arbiter.sv
// tb/tb_sd_drive_arbiter.sv - directed self-checking bench with a transaction-level model
module tb_sd_drive_arbiter;

    localparam int NB = 4;
    localparam int LW = 32;
    localparam int TO = 16;

    logic                   clk_sys = 1'b0;
    logic                   reset;
    logic [NB-1:0][LW-1:0]  drv_lba;
    logic [NB-1:0]          drv_rd, drv_wr;
    logic [NB-1:0][7:0]     drv_buff_din;
    logic [NB-1:0]          drv_ack, drv_done, drv_err, drv_buff_wr;
    logic [NB-1:0][LW-1:0]  sd_lba;
    logic [NB-1:0]          sd_rd, sd_wr, sd_ack;
    logic                   sd_buff_wr;
    logic [NB-1:0][7:0]     sd_buff_din;
    logic [NB-1:0]          img_mounted;
    logic                   grant_valid;
    logic [1:0]             grant_id;

    sd_drive_arbiter #(.NBDRIV(NB), .LBA_W(LW), .TIMEOUT(TO)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .drv_lba      (drv_lba),
        .drv_rd       (drv_rd),
        .drv_wr       (drv_wr),
        .drv_buff_din (drv_buff_din),
        .drv_ack      (drv_ack),
        .drv_done     (drv_done),
        .drv_err      (drv_err),
        .drv_buff_wr  (drv_buff_wr),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din),
        .img_mounted  (img_mounted),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id)
    );

    always #5 clk_sys = ~clk_sys;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // transaction-level model: who owns the channel and what phase it is in
    int              m_owner = -1;
    int              m_last  = NB - 1;
    int              m_err   = -1;
    bit              m_rd = 0, m_wait_ack = 0, m_moving = 0, m_closing = 0;
    logic [LW-1:0]   m_lba = '0;
    int              m_issue_cyc = 0;

    int done_cnt [NB];
    int err_cnt  [NB];
    int bw_cnt   [NB];
    int glog_id[$];
    int glog_rd[$];
    bit prev_gv = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        int nerr;
        bit found;
        nerr = -1;
        if (reset) begin
            m_owner = -1; m_last = NB - 1; m_err = -1;
            m_wait_ack = 0; m_moving = 0; m_closing = 0;
        end else begin
            if (m_owner < 0) begin
                found = 0;
                for (int k = 1; k <= NB; k++) begin
                    int j;
                    j = (m_last + k) % NB;
                    if (!found && (drv_rd[j] || drv_wr[j]) && j != m_err) begin
                        found = 1;
                        m_owner = j; m_rd = drv_rd[j]; m_lba = drv_lba[j];
                        m_wait_ack = 1; m_issue_cyc = cyc + 1;
                    end
                end
            end else if (m_wait_ack) begin
                if (sd_ack[m_owner]) begin
                    m_wait_ack = 0; m_moving = 1;
                end else if (img_mounted[m_owner] || (cyc - m_issue_cyc == TO - 1)) begin
                    nerr = m_owner; m_owner = -1; m_wait_ack = 0;
                end
            end else if (m_moving) begin
                if (!sd_ack[m_owner]) begin
                    m_moving = 0; m_closing = 1;
                end
            end else if (m_closing) begin
                m_last = m_owner; m_owner = -1; m_closing = 0;
            end
            m_err = nerr;
        end
        cyc++;
    endtask

    task automatic compare_all();
        logic [NB-1:0] e_rd, e_wr, e_ack, e_bw, e_done, e_err;
        logic [LW-1:0] e_lba [NB];
        e_rd = '0; e_wr = '0; e_ack = '0; e_bw = '0; e_done = '0; e_err = '0;
        for (int i = 0; i < NB; i++) e_lba[i] = '0;
        if (m_owner >= 0) begin
            e_lba[m_owner]  = m_lba;
            e_rd[m_owner]   = m_wait_ack && m_rd;
            e_wr[m_owner]   = m_wait_ack && !m_rd;
            e_ack[m_owner]  = m_moving;
            e_bw[m_owner]   = m_moving && sd_buff_wr;
            e_done[m_owner] = m_closing;
        end
        if (m_err >= 0) e_err[m_err] = 1'b1;
        chk("sd_rd", sd_rd, e_rd);
        chk("sd_wr", sd_wr, e_wr);
        chk("drv_ack", drv_ack, e_ack);
        chk("drv_buff_wr", drv_buff_wr, e_bw);
        chk("drv_done", drv_done, e_done);
        chk("drv_err", drv_err, e_err);
        chk("grant_valid", grant_valid, m_owner >= 0);
        chk("grant_id", grant_id, (m_owner >= 0) ? m_owner : 0);
        for (int i = 0; i < NB; i++) begin
            chk("sd_lba", sd_lba[i], e_lba[i]);
            chk("sd_buff_din", sd_buff_din[i], drv_buff_din[i]);
        end
    endtask

    // one clock: update model, check outputs, log events, then let drives react
    task automatic tick();
        @(posedge clk_sys);
        model_step();
        #1;
        compare_all();
        for (int i = 0; i < NB; i++) begin
            if (drv_done[i])    done_cnt[i]++;
            if (drv_err[i])     err_cnt[i]++;
            if (drv_buff_wr[i]) bw_cnt[i]++;
        end
        if (grant_valid && !prev_gv) begin
            glog_id.push_back(int'(grant_id));
            glog_rd.push_back(int'(sd_rd[grant_id]));
        end
        prev_gv = grant_valid;
        @(negedge clk_sys);
        for (int i = 0; i < NB; i++) begin
            if (drv_done[i] || drv_err[i]) begin
                if (drv_rd[i]) drv_rd[i] = 1'b0;
                else           drv_wr[i] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drv_rd = '0; drv_wr = '0; sd_ack = '0; sd_buff_wr = 1'b0; img_mounted = '0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic serve(input int want, input int n);
        int t, i;
        t = 0;
        while (t < 50 && !((want < 0) ? |(sd_rd | sd_wr) : (sd_rd[want] | sd_wr[want]))) begin
            tick(); t++;
        end
        i = 0;
        for (int k = 0; k < NB; k++) if (sd_rd[k] | sd_wr[k]) i = k;
        if (want >= 0) i = want;
        chk("serve_issue_seen", sd_rd[i] | sd_wr[i], 1);
        sd_ack[i] = 1'b1;
        tick();
        for (int s = 0; s < n; s++) begin
            sd_buff_wr = 1'b1; tick();
            sd_buff_wr = 1'b0; tick();
        end
        sd_ack[i] = 1'b0;
        tick();
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sd_rd"}, sd_rd, 0);
        chk({tag, "_sd_wr"}, sd_wr, 0);
        chk({tag, "_drv_ack"}, drv_ack, 0);
        chk({tag, "_drv_done"}, drv_done, 0);
        chk({tag, "_drv_err"}, drv_err, 0);
        chk({tag, "_drv_buff_wr"}, drv_buff_wr, 0);
        chk({tag, "_grant"}, {grant_valid, grant_id}, 0);
        chk({tag, "_sd_lba"}, sd_lba, 0);
    endtask

    initial begin
        int base, t, t0, d1, e1;
        reset = 1'b1;
        drv_lba = '0; drv_rd = '0; drv_wr = '0; sd_ack = '0; sd_buff_wr = 1'b0;
        img_mounted = '0;
        for (int i = 0; i < NB; i++) begin
            drv_buff_din[i] = 8'hA0 + 8'(i);
            done_cnt[i] = 0; err_cnt[i] = 0; bw_cnt[i] = 0;
        end
        do_reset();
        chk_all_zero("reset_state");

        // single read on drive 2, 512 strobes
        drv_lba[2] = 32'h1234;
        drv_rd[2]  = 1'b1;
        tick();
        chk("t1_sd_rd2", sd_rd, 4'b0100);
        chk("t1_sd_lba2", sd_lba[2], 32'h1234);
        chk("t1_grant_id", grant_id, 2);
        serve(2, 512);
        chk("t1_buff_wr_count", bw_cnt[2], 512);
        chk("t1_done_count", done_cnt[2], 1);
        chk("t1_err_count", err_cnt[2], 0);

        // round robin among 0,1,3 with drive 0 coming back
        do_reset();
        glog_id.delete(); glog_rd.delete();
        drv_lba[0] = 32'h100; drv_lba[1] = 32'h200; drv_lba[3] = 32'h300;
        drv_rd[0] = 1'b1; drv_rd[1] = 1'b1; drv_rd[3] = 1'b1;
        serve(-1, 2);
        drv_wr[0] = 1'b1;
        serve(-1, 2);
        serve(-1, 2);
        serve(-1, 2);
        chk("t2_grant_count", glog_id.size(), 4);
        chk("t2_grant0", glog_id[0], 0);
        chk("t2_grant1", glog_id[1], 1);
        chk("t2_grant2", glog_id[2], 3);
        chk("t2_grant3", glog_id[3], 0);
        chk("t2_grant3_is_write", glog_rd[3], 0);

        // read and write on drive 1 together
        base = glog_id.size();
        drv_rd[1] = 1'b1; drv_wr[1] = 1'b1;
        serve(1, 1);
        serve(1, 1);
        chk("t3_grant_count", glog_id.size(), base + 2);
        chk("t3_first_id", glog_id[base], 1);
        chk("t3_first_is_read", glog_rd[base], 1);
        chk("t3_second_id", glog_id[base + 1], 1);
        chk("t3_second_is_write", glog_rd[base + 1], 0);

        // timeout with no ack
        do_reset();
        d1 = done_cnt[2]; e1 = err_cnt[2];
        drv_lba[2] = 32'hCAFE; drv_wr[2] = 1'b1;
        t = 0;
        while (t < 10 && !sd_wr[2]) begin tick(); t++; end
        chk("t4_issue_seen", sd_wr[2], 1);
        t0 = cyc;
        t = 0;
        while (t < 40 && !drv_err[2]) begin tick(); t++; end
        chk("t4_err_seen", drv_err[2], 1);
        chk("t4_err_delay", cyc - t0, 16);
        tick();
        chk("t4_no_done", done_cnt[2] - d1, 0);
        chk("t4_one_err", err_cnt[2] - e1, 1);

        // foreign ack ignored, mount change aborts
        do_reset();
        e1 = err_cnt[0]; d1 = done_cnt[0];
        drv_lba[0] = 32'h55; drv_rd[0] = 1'b1;
        tick();
        chk("t5_issue0", sd_rd[0], 1);
        sd_ack[3] = 1'b1;
        tick();
        chk("t5_still_issuing", sd_rd[0], 1);
        chk("t5_no_window", drv_ack, 0);
        sd_ack[3] = 1'b0;
        img_mounted[0] = 1'b1;
        tick();
        img_mounted[0] = 1'b0;
        chk("t5_err0", drv_err, 4'b0001);
        tick();
        chk("t5_err_count", err_cnt[0] - e1, 1);
        chk("t5_no_done", done_cnt[0] - d1, 0);

        // reset during transfer
        do_reset();
        d1 = done_cnt[1]; e1 = err_cnt[1];
        drv_lba[1] = 32'h777; drv_rd[1] = 1'b1;
        tick();
        sd_ack[1] = 1'b1;
        tick();
        sd_buff_wr = 1'b1; drv_rd[0] = 1'b1; drv_rd[3] = 1'b1;
        tick();
        chk("t6_in_window", drv_ack, 4'b0010);
        sd_buff_wr = 1'b0;
        drv_buff_din = '0;
        reset = 1'b1;
        tick();
        chk_all_zero("t6_after_reset");
        chk("t6_buff_din_zero", sd_buff_din, 0);
        reset = 1'b0; sd_ack[1] = 1'b0; drv_rd[1] = 1'b0;
        t = 0;
        while (t < 10 && !grant_valid) begin tick(); t++; end
        chk("t6_next_grant_valid", grant_valid, 1);
        chk("t6_next_grant_drive0", grant_id, 0);
        serve(0, 1);
        serve(3, 1);
        chk("t6_no_done_drive1", done_cnt[1] - d1, 0);
        chk("t6_no_err_drive1", err_cnt[1] - e1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
